// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI PSRAM arbiter: FSM encoding,
// master ids and the latched command record.
package qspi_arb_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ISSUE   = 3'd1;
   localparam logic [2:0] ST_RD_WAIT = 3'd2;
   localparam logic [2:0] ST_WR_WAIT = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_ISSUE   = ST_ISSUE,
      S_RD_WAIT = ST_RD_WAIT,
      S_WR_WAIT = ST_WR_WAIT,
      S_DONE    = ST_DONE
   } state_e;

   localparam logic M_FETCH = 1'b0;
   localparam logic M_DATA  = 1'b1;

   typedef struct packed {
      logic        id;
      logic        we;
      logic        w;
      logic        hw;
      logic [31:0] adr;
      logic [31:0] wdata;
   } cmd_t;

endpackage

// File: rtl/qspi_mem_arbiter_if.sv
// Read/write handshake between the arbiter (master) and the QSPI PSRAM
// controller (slave).
interface qspi_mem_arbiter_if;

   logic        read_req;
   logic        read_w;
   logic        read_hw;
   logic [31:0] read_adr;
   logic        read_valid;
   logic [31:0] read_data;

   logic        write_req;
   logic        write_w;
   logic        write_hw;
   logic [31:0] write_adr;
   logic [31:0] write_data;
   logic        write_finish;

   modport master (
      output read_req, read_w, read_hw, read_adr,
      input  read_valid, read_data,
      output write_req, write_w, write_hw, write_adr, write_data,
      input  write_finish
   );

   modport slave (
      input  read_req, read_w, read_hw, read_adr,
      output read_valid, read_data,
      input  write_req, write_w, write_hw, write_adr, write_data,
      output write_finish
   );

endinterface

// File: rtl/qspi_arb_rr2.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to
// the master that was not served last.
module qspi_arb_rr2
   import qspi_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       grant_id_o,
   output logic       grant_valid_o
);

   always_comb begin
      // NOTE: every output gets a default before any branch so no latch is inferred.
      grant_id_o    = M_FETCH;
      grant_valid_o = |req_i;
      if (req_i[1] && req_i[0]) begin
         grant_id_o = ~last_grant_i;
      end else if (req_i[1]) begin
         grant_id_o = M_DATA;
      end
   end

endmodule

// File: rtl/qspi_mem_arbiter.sv
// Shares one QSPI PSRAM controller between instruction fetch (m0) and data
// load/store (m1): round-robin grant, single-cycle controller requests, watchdog.
module qspi_mem_arbiter
   import qspi_arb_pkg::*;
#(
   parameter int unsigned      TMO_W   = 16,
   parameter logic [TMO_W-1:0] TMO_CYC = 16'd4000
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      m0_req,
   input  logic [31:0]               m0_adr,
   output logic                      m0_done,
   output logic [31:0]               m0_rdata,

   input  logic                      m1_req,
   input  logic                      m1_we,
   input  logic                      m1_w,
   input  logic                      m1_hw,
   input  logic [31:0]               m1_adr,
   input  logic [31:0]               m1_wdata,
   output logic                      m1_done,
   output logic [31:0]               m1_rdata,

   output logic                      tmo_err,

   qspi_mem_arbiter_if.master        ctrl
);

   state_e            state_q;
   logic              last_grant_q;
   logic [TMO_W-1:0]  wdog_q;
   logic [TMO_W-1:0]  wdog_d;
   cmd_t              cmd_q;
   cmd_t              cmd_d;
   logic              read_req_q;
   logic              write_req_q;
   logic              m0_done_q;
   logic              m1_done_q;
   logic              tmo_err_q;
   logic [31:0]       m0_rdata_q;
   logic [31:0]       m1_rdata_q;

   logic              grant_id;
   logic              grant_valid;
   logic              tmo_hit;
   logic              resp_hit;
   logic              cap_en;
   logic [31:0]       cap_data;

   qspi_arb_rr2 u_rr2 (
      .req_i         ({m1_req, m0_req}),
      .last_grant_i  (last_grant_q),
      .grant_id_o    (grant_id),
      .grant_valid_o (grant_valid)
   );

   // Fetch is always a word read; only the data port carries size and write data.
   always_comb begin
      cmd_d    = '0;
      cmd_d.id = grant_id;
      if (grant_id == M_DATA) begin
         cmd_d.we    = m1_we;
         cmd_d.w     = m1_w;
         cmd_d.hw    = m1_hw;
         cmd_d.adr   = m1_adr;
         cmd_d.wdata = m1_wdata;
      end else begin
         cmd_d.w   = 1'b1;
         cmd_d.adr = m0_adr;
      end
   end

   // A response in the same cycle as watchdog expiry wins; a write only
   // touches rdata when it is aborted.
   always_comb begin
      wdog_d   = wdog_q + TMO_W'(1);
      tmo_hit  = (TMO_CYC != '0) && (wdog_d == TMO_CYC);
      resp_hit = (state_q == S_RD_WAIT) ? ctrl.read_valid : ctrl.write_finish;
      cap_en   = (state_q == S_RD_WAIT) || !resp_hit;
      cap_data = resp_hit ? ctrl.read_data : 32'h0000_0000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= M_DATA;
         wdog_q       <= '0;
         cmd_q        <= '0;
         read_req_q   <= 1'b0;
         write_req_q  <= 1'b0;
         m0_done_q    <= 1'b0;
         m1_done_q    <= 1'b0;
         tmo_err_q    <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
         read_req_q  <= 1'b0;
         write_req_q <= 1'b0;
         m0_done_q   <= 1'b0;
         m1_done_q   <= 1'b0;
         tmo_err_q   <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (grant_valid) begin
                  cmd_q       <= cmd_d;
                  read_req_q  <= ~cmd_d.we;
                  write_req_q <= cmd_d.we;
                  state_q     <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               wdog_q  <= '0;
               state_q <= cmd_q.we ? S_WR_WAIT : S_RD_WAIT;
            end

            S_RD_WAIT, S_WR_WAIT: begin
               if (resp_hit || tmo_hit) begin
                  state_q   <= S_DONE;
                  m0_done_q <= (cmd_q.id == M_FETCH);
                  m1_done_q <= (cmd_q.id == M_DATA);
                  tmo_err_q <= ~resp_hit;
                  if (cap_en) begin
                     if (cmd_q.id == M_DATA) begin
                        m1_rdata_q <= cap_data;
                     end else begin
                        m0_rdata_q <= cap_data;
                     end
                  end
               end else begin
                  wdog_q <= wdog_d;
               end
            end

            S_DONE: begin
               last_grant_q <= cmd_q.id;
               state_q      <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign m0_done  = m0_done_q;
   assign m0_rdata = m0_rdata_q;
   assign m1_done  = m1_done_q;
   assign m1_rdata = m1_rdata_q;
   assign tmo_err  = tmo_err_q;

   assign ctrl.read_req   = read_req_q;
   assign ctrl.read_w     = cmd_q.w;
   assign ctrl.read_hw    = cmd_q.hw;
   assign ctrl.read_adr   = cmd_q.adr;
   assign ctrl.write_req  = write_req_q;
   assign ctrl.write_w    = cmd_q.w;
   assign ctrl.write_hw   = cmd_q.hw;
   assign ctrl.write_adr  = cmd_q.adr;
   assign ctrl.write_data = cmd_q.wdata;

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// Scoreboard bench for qspi_mem_arbiter: directed requester traffic, a small
// PSRAM controller model, and monitors comparing commands and completions.
module tb_qspi_mem_arbiter;

   localparam int TMO = 8;

   typedef struct {
      logic        id;
      logic [31:0] rdata;
      logic        tmo;
   } exp_t;

   typedef struct {
      logic        wr;
      logic        w;
      logic        hw;
      logic [31:0] adr;
      logic [31:0] data;
   } cmd_exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0;
   logic [31:0] m0_adr = '0;
   logic        m0_done;
   logic [31:0] m0_rdata;
   logic        m1_req = 1'b0;
   logic        m1_we = 1'b0;
   logic        m1_w = 1'b0;
   logic        m1_hw = 1'b0;
   logic [31:0] m1_adr = '0;
   logic [31:0] m1_wdata = '0;
   logic        m1_done;
   logic [31:0] m1_rdata;
   logic        tmo_err;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int ctrl_delay = 1;
   int exp_done_cyc = 0;
   int outstanding = 0;

   exp_t        sb[$];
   cmd_exp_t    cmd_q[$];
   logic [31:0] rd_q[$];

   qspi_mem_arbiter_if ctrl ();

   qspi_mem_arbiter #(
      .TMO_W   (16),
      .TMO_CYC (16'd8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m0_req   (m0_req),
      .m0_adr   (m0_adr),
      .m0_done  (m0_done),
      .m0_rdata (m0_rdata),
      .m1_req   (m1_req),
      .m1_we    (m1_we),
      .m1_w     (m1_w),
      .m1_hw    (m1_hw),
      .m1_adr   (m1_adr),
      .m1_wdata (m1_wdata),
      .m1_done  (m1_done),
      .m1_rdata (m1_rdata),
      .tmo_err  (tmo_err),
      .ctrl     (ctrl)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name, input string msg);
      n_checks++;
      n_errors++;
      $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
   endtask

   task automatic exp_done(input logic id, input logic [31:0] rdata, input logic tmo);
      exp_t e;
      e.id = id; e.rdata = rdata; e.tmo = tmo;
      sb.push_back(e);
   endtask

   task automatic exp_cmd(input logic wr, input logic w, input logic hw,
                          input logic [31:0] adr, input logic [31:0] data);
      cmd_exp_t c;
      c.wr = wr; c.w = w; c.hw = hw; c.adr = adr; c.data = data;
      cmd_q.push_back(c);
   endtask

   task automatic wait_done(input logic id);
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = id ? m1_done : m0_done;
      end
      if (!got) fail(id ? "m1_done_wait" : "m0_done_wait", "no done within 200 cycles");
   endtask

   task automatic m0_access(input logic [31:0] adr);
      m0_adr = adr;
      m0_req = 1'b1;
      wait_done(1'b0);
      m0_req = 1'b0;
   endtask

   task automatic m1_access(input logic we, input logic w, input logic hw,
                            input logic [31:0] adr, input logic [31:0] wdata);
      m1_we = we; m1_w = w; m1_hw = hw; m1_adr = adr; m1_wdata = wdata;
      m1_req = 1'b1;
      wait_done(1'b1);
      m1_req = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_m0_done"},  32'(m0_done), 32'd0);
      check({tag, "_m1_done"},  32'(m1_done), 32'd0);
      check({tag, "_tmo_err"},  32'(tmo_err), 32'd0);
      check({tag, "_m0_rdata"}, m0_rdata, 32'd0);
      check({tag, "_m1_rdata"}, m1_rdata, 32'd0);
      check({tag, "_read_req"}, 32'(ctrl.read_req), 32'd0);
      check({tag, "_write_req"}, 32'(ctrl.write_req), 32'd0);
      check({tag, "_read_adr"}, ctrl.read_adr, 32'd0);
      check({tag, "_write_data"}, ctrl.write_data, 32'd0);
   endtask

   // Controller model: checks each issued command, then answers after
   // ctrl_delay cycles unless reset intervenes.
   initial begin : ctrl_model
      logic     wr;
      int       req_c;
      int       dly;
      bit       abort;
      cmd_exp_t c;
      ctrl.read_valid   = 1'b0;
      ctrl.write_finish = 1'b0;
      ctrl.read_data    = '0;
      forever begin
         @(negedge clk);
         if (!rst && (ctrl.read_req || ctrl.write_req)) begin
            wr    = ctrl.write_req;
            req_c = cyc;
            dly   = ctrl_delay;
            if (cmd_q.size() == 0) begin
               fail("unexpected_req", "controller request with nothing expected");
            end else begin
               c = cmd_q.pop_front();
               check("cmd_is_write", 32'(wr), 32'(c.wr));
               check("cmd_adr",  wr ? ctrl.write_adr : ctrl.read_adr, c.adr);
               check("cmd_w",    32'(wr ? ctrl.write_w : ctrl.read_w), 32'(c.w));
               check("cmd_hw",   32'(wr ? ctrl.write_hw : ctrl.read_hw), 32'(c.hw));
               if (wr) check("cmd_wdata", ctrl.write_data, c.data);
            end
            exp_done_cyc = (dly <= TMO) ? req_c + dly + 1 : req_c + TMO + 1;
            abort = 1'b0;
            @(negedge clk);
            check("req_pulse_width", 32'(ctrl.read_req | ctrl.write_req), 32'd0);
            if (rst) abort = 1'b1;
            for (int i = 1; i < dly && !abort; i++) begin
               @(negedge clk);
               if (rst) abort = 1'b1;
            end
            if (!abort) begin
               if (wr) begin
                  ctrl.write_finish = 1'b1;
               end else begin
                  ctrl.read_valid = 1'b1;
                  ctrl.read_data  = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
               end
               @(negedge clk);
               ctrl.read_valid   = 1'b0;
               ctrl.write_finish = 1'b0;
            end
         end
      end
   end

   // Completion monitor: pops the scoreboard on every done pulse.
   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst) begin
         if (tmo_err && !m0_done && !m1_done) fail("tmo_err_alone", "tmo_err without done");
         if (m0_done || m1_done) begin
            check("done_exclusive", 32'(m0_done & m1_done), 32'd0);
            if (sb.size() == 0) begin
               fail("unexpected_done", "done pulse with empty scoreboard");
            end else begin
               mon_e = sb.pop_front();
               check("done_id",    32'(m1_done), 32'(mon_e.id));
               check("done_rdata", mon_e.id ? m1_rdata : m0_rdata, mon_e.rdata);
               check("done_tmo",   32'(tmo_err), 32'(mon_e.tmo));
               check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
            end
         end
      end
   end

   // At most one controller request outstanding at any time.
   always @(negedge clk) begin
      if (rst) begin
         outstanding = 0;
      end else begin
         if (ctrl.read_req || ctrl.write_req) begin
            check("one_outstanding", 32'(outstanding), 32'd0);
            check("req_exclusive", 32'(ctrl.read_req & ctrl.write_req), 32'd0);
            outstanding = 1;
         end
         if (m0_done || m1_done) outstanding = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int n_done;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // Fetch only: word read, 5-cycle controller latency.
      exp_cmd(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
      rd_q.push_back(32'hDEAD_BEEF);
      exp_done(1'b0, 32'hDEAD_BEEF, 1'b0);
      ctrl_delay = 5;
      fork
         m0_access(32'h100);
         begin
            @(negedge clk);
            check("fetch_req_latency", 32'(ctrl.read_req), 32'd1);
         end
      join
      repeat (2) @(negedge clk);

      // Data halfword write; m1_rdata keeps its reset value.
      exp_cmd(1'b1, 1'b0, 1'b1, 32'h202, 32'h0000_1234);
      exp_done(1'b1, 32'h0, 1'b0);
      ctrl_delay = 3;
      m1_access(1'b1, 1'b0, 1'b1, 32'h202, 32'h0000_1234);
      repeat (2) @(negedge clk);

      // Data byte read with single-cycle latency.
      exp_cmd(1'b0, 1'b0, 1'b0, 32'h203, 32'h0);
      rd_q.push_back(32'h0000_00AB);
      exp_done(1'b1, 32'h0000_00AB, 1'b0);
      ctrl_delay = 1;
      m1_access(1'b0, 1'b0, 1'b0, 32'h203, 32'h0);
      repeat (2) @(negedge clk);

      // Contention: both held for four transactions, m1 served last so m0 leads.
      exp_cmd(1'b0, 1'b1, 1'b0, 32'h400, 32'h0);
      exp_cmd(1'b0, 1'b1, 1'b0, 32'h500, 32'h0);
      exp_cmd(1'b0, 1'b1, 1'b0, 32'h400, 32'h0);
      exp_cmd(1'b0, 1'b1, 1'b0, 32'h500, 32'h0);
      rd_q.push_back(32'h1111_1111);
      rd_q.push_back(32'h2222_2222);
      rd_q.push_back(32'h3333_3333);
      rd_q.push_back(32'h4444_4444);
      exp_done(1'b0, 32'h1111_1111, 1'b0);
      exp_done(1'b1, 32'h2222_2222, 1'b0);
      exp_done(1'b0, 32'h3333_3333, 1'b0);
      exp_done(1'b1, 32'h4444_4444, 1'b0);
      ctrl_delay = 2;
      m0_adr = 32'h400;
      m1_we = 1'b0; m1_w = 1'b1; m1_hw = 1'b0; m1_adr = 32'h500;
      m0_req = 1'b1;
      m1_req = 1'b1;
      n_done = 0;
      for (int i = 0; i < 400 && n_done < 4; i++) begin
         @(negedge clk);
         if (m0_done || m1_done) n_done++;
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      if (n_done < 4) fail("contention_wait", "fewer than 4 completions");
      repeat (2) @(negedge clk);

      // Response in the same cycle the watchdog would expire: data wins.
      exp_cmd(1'b0, 1'b1, 1'b0, 32'h600, 32'h0);
      rd_q.push_back(32'hCAFE_F00D);
      exp_done(1'b0, 32'hCAFE_F00D, 1'b0);
      ctrl_delay = TMO;
      m0_access(32'h600);
      repeat (2) @(negedge clk);

      // Timeout: response arrives late and must be ignored.
      exp_cmd(1'b0, 1'b1, 1'b0, 32'h700, 32'h0);
      rd_q.push_back(32'hBAD0_BAD0);
      exp_done(1'b0, 32'h0, 1'b1);
      ctrl_delay = 12;
      m0_access(32'h700);
      repeat (10) @(negedge clk);
      check("late_valid_ignored", m0_rdata, 32'h0);

      // Normal fetch after the timeout.
      exp_cmd(1'b0, 1'b1, 1'b0, 32'h704, 32'h0);
      rd_q.push_back(32'h0BAD_F00D);
      exp_done(1'b0, 32'h0BAD_F00D, 1'b0);
      ctrl_delay = 2;
      m0_access(32'h704);
      repeat (2) @(negedge clk);

      // Reset during RD_WAIT: outputs clear, no completion.
      exp_cmd(1'b0, 1'b1, 1'b0, 32'h800, 32'h0);
      ctrl_delay = 20;
      m0_adr = 32'h800;
      m0_req = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      m0_req = 1'b0;
      @(negedge clk);
      check_all_zero("rst_mid");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Tie right after reset: last_grant restarts at m1, so m0 goes first.
      exp_cmd(1'b0, 1'b1, 1'b0, 32'h900, 32'h0);
      exp_cmd(1'b1, 1'b1, 1'b0, 32'hA00, 32'hA5A5_A5A5);
      rd_q.push_back(32'h5555_5555);
      exp_done(1'b0, 32'h5555_5555, 1'b0);
      exp_done(1'b1, 32'h0, 1'b0);
      ctrl_delay = 3;
      fork
         m0_access(32'h900);
         m1_access(1'b1, 1'b1, 1'b0, 32'hA00, 32'hA5A5_A5A5);
      join
      repeat (5) @(negedge clk);

      check("sb_drained",  32'(sb.size()), 32'd0);
      check("cmd_drained", 32'(cmd_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
